// File: rtl/cpu_bus_master.sv
// CPU-side bus initiator: turns one core byte request into one 4-phase
// machine cycle on the system bus. All bus strobes are registered so they
// only move on clock edges; DMA-blocked cycles keep their timing but never
// assert a strobe.
//
// Handshake: req_ready = req_valid && phase==3, purely combinational; the
// request is taken on that same clock edge and the core must hold req_valid
// and its fields stable until then. rsp_valid is a one-clock pulse in phase 3
// of the cycle that ran the request, with no backpressure.
module cpu_bus_master #(
   parameter int         PHASES   = 4,
   parameter logic [7:0] OPEN_BUS = 8'hFF
) (
   input  logic        clk,
   input  logic        nreset,
   input  logic        req_valid,
   input  logic        req_wr,
   input  logic [15:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   input  logic        dma_busy,
   output logic [15:0] a,
   input  logic [7:0]  d_in,
   output logic [7:0]  d_out,
   output logic        d_oe,
   output logic        cpu_raw_rd,
   output logic        cpu_rd_sync,
   output logic        cpu_wr_raw,
   output logic [1:0]  phase,
   output logic        mcyc_start,
   output logic        blocked
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_RD = 2'd1,
      BUSY_WR = 2'd2
   } state_t;

   localparam logic [1:0] LAST_PHASE = 2'(PHASES - 1);

   state_t     state;
   state_t     state_nxt;
   logic [1:0] phase_nxt;
   logic       blocked_nxt;
   logic       accept;
   logic       hram_hit;
   logic       live_rd_nxt;
   logic       live_wr_nxt;
   logic       raw_rd_nxt;
   logic       rd_sync_nxt;
   logic       wr_raw_nxt;
   logic       d_oe_nxt;
   logic       rsp_valid_nxt;

   // Requests are only taken at the last phase so every access lines up with a machine cycle.
   assign accept     = req_valid && (phase == LAST_PHASE);
   assign req_ready  = accept;
   assign mcyc_start = (phase == 2'd0);
   // HRAM stays reachable during OAM DMA; FFFF (IE register) is outside it.
   assign hram_hit   = (req_addr >= 16'hFF80) && (req_addr <= 16'hFFFE);

   // Next state, next phase and the strobe values for the coming phase.
   always_comb begin
      state_nxt   = state;
      blocked_nxt = blocked;
      phase_nxt   = phase + 2'd1;
      if (phase == LAST_PHASE) begin
         if (accept) begin
            state_nxt   = req_wr ? BUSY_WR : BUSY_RD;
            blocked_nxt = dma_busy && !hram_hit;
         end else begin
            state_nxt   = IDLE;
            blocked_nxt = 1'b0;
         end
      end
      live_rd_nxt   = (state_nxt == BUSY_RD) && !blocked_nxt;
      live_wr_nxt   = (state_nxt == BUSY_WR) && !blocked_nxt;
      raw_rd_nxt    = live_rd_nxt;
      rd_sync_nxt   = live_rd_nxt && ((phase_nxt == 2'd1) || (phase_nxt == 2'd2));
      wr_raw_nxt    = live_wr_nxt && phase_nxt[1];
      d_oe_nxt      = live_wr_nxt && (phase_nxt != 2'd0);
      rsp_valid_nxt = (state_nxt != IDLE) && (phase_nxt == LAST_PHASE);
   end

   // FSM state, free-running phase counter and the per-cycle blocked flag.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state   <= IDLE;
         phase   <= 2'd0;
         blocked <= 1'b0;
      end else begin
         state   <= state_nxt;
         phase   <= phase_nxt;
         blocked <= blocked_nxt;
      end
   end

   // Registered strobes and response pulse so the bus sees no combinational glitches.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         cpu_raw_rd  <= 1'b0;
         cpu_rd_sync <= 1'b0;
         cpu_wr_raw  <= 1'b0;
         d_oe        <= 1'b0;
         rsp_valid   <= 1'b0;
      end else begin
         cpu_raw_rd  <= raw_rd_nxt;
         cpu_rd_sync <= rd_sync_nxt;
         cpu_wr_raw  <= wr_raw_nxt;
         d_oe        <= d_oe_nxt;
         rsp_valid   <= rsp_valid_nxt;
      end
   end

   // Latch the request address (and write data) on the accepting edge; held through IDLE.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         a     <= 16'h0000;
         d_out <= 8'h00;
      end else if (accept) begin
         a <= req_addr;
         if (req_wr) begin
            d_out <= req_wdata;
         end
      end
   end

   // Capture read data on the edge ending phase 2; blocked reads see open bus.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         rsp_rdata <= 8'h00;
      end else if ((state == BUSY_RD) && (phase == 2'd2)) begin
         rsp_rdata <= blocked ? OPEN_BUS : d_in;
      end
   end

endmodule
